// File: rtl/muldiv_unit_pkg.sv
// Shared datapath types: ALU control codes plus the multiply/divide unit's
// state and operation encodings.
package global_types;

  typedef enum logic [3:0] {
    ADDac, SUBac, ANDac, ORac, XORac, NORac, SLTac, SLLac,
    SRLac, LUIac, MULTUac, DIVUac, MFHIac, MFLOac
  } alu_ctrl_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

  typedef enum logic {MD_MULTU, MD_DIVU} muldiv_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU engine owning the HI/LO registers.
// Handshake: a start is accepted only outside RUN; busy marks the iteration
// window and done pulses for one cycle on the cycle HI/LO first show a result.
module muldiv_unit
  import global_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  alu_ctrl_t            alu_ctrl,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 div_by_zero,
  output muldiv_state_t        dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_t      r_state;
  muldiv_state_t      w_state_nxt;
  muldiv_op_t         r_op;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_accept;
  logic               w_zero_start;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_shl;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH:0]   w_acc_nxt;

  assign w_is_mul     = (alu_ctrl == MULTUac);
  assign w_is_div     = (alu_ctrl == DIVUac);
  assign w_accept     = start && (w_is_mul || (w_is_div && (b != '0)));
  assign w_zero_start = start && w_is_div && (b == '0);

  // Accumulator is {rem/upper (WIDTH+1), lower (WIDTH)}; the extra top bit
  // holds the add carry for MULTU and the subtract borrow for DIVU.
  assign w_sum  = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_shl  = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_diff = w_shl[2*WIDTH:WIDTH] - {1'b0, r_opnd};

  always_comb begin
    w_acc_nxt = r_acc;
    if (r_op == MD_MULTU) begin
      w_acc_nxt = {1'b0, w_sum, r_acc[WIDTH-1:1]};
    end else if (w_diff[WIDTH]) begin
      w_acc_nxt = w_shl;
    end else begin
      w_acc_nxt = {w_diff, w_shl[WIDTH-1:1], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept)          w_state_nxt = RUN;
        else if (w_zero_start) w_state_nxt = DONE;
        else                   w_state_nxt = IDLE;
      end
      RUN:     if (r_cnt == LAST) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= MD_MULTU;
      r_cnt  <= '0;
      r_opnd <= '0;
      r_acc  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dbz  <= 1'b0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      if (r_cnt != LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
        r_lo <= w_acc_nxt[WIDTH-1:0];
      end
    end else if (w_accept) begin
      r_op   <= w_is_mul ? MD_MULTU : MD_DIVU;
      r_opnd <= w_is_mul ? a : b;
      r_acc  <= {{(WIDTH+1){1'b0}}, (w_is_mul ? b : a)};
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_zero_start) begin
      r_hi  <= a;
      r_lo  <= '1;
      r_dbz <= 1'b1;
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, divide-by-zero, ignored
// starts, reset abort and back-to-back operation with HI/LO hold.
module tb_muldiv_unit;
  import global_types::*;

  localparam int W = 32;
  localparam alu_ctrl_t TB_MULTUc = MULTUac;
  localparam alu_ctrl_t TB_DIVUc  = DIVUac;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  alu_ctrl_t     alu_ctrl;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;
  muldiv_state_t dbg_state;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*W-1:0] golden(input alu_ctrl_t op,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [2*W-1:0] p;
    if (op == TB_MULTUc) p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else if (y == '0)    p = {x, {W{1'b1}}};
    else                 p = {x % y, x / y};
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse; returns one time unit into cycle 1.
  task automatic issue(input alu_ctrl_t op, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; alu_ctrl = op; a = x; b = y;
    step();
    start = 1'b0; alu_ctrl = ADDac;
  endtask

  task automatic run_op(input string tag, input alu_ctrl_t op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int bad;
    bad = 0;
    done_seen = 0;
    issue(op, x, y);
    chk({tag, "_dbz_clear"}, div_by_zero, 0);
    for (int c = 1; c <= W; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    chk({tag, "_busy_window"}, bad, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    step();
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_one_pulse"}, done_seen, 1);
  endtask

  initial begin
    logic [2*W-1:0] g;
    int bad;

    rst = 1'b1; start = 1'b0; alu_ctrl = ADDac; a = '0; b = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    step();

    run_op("multu_max", TB_MULTUc, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu_100_7", TB_DIVUc, 32'd100, 32'd7, 32'd2, 32'd14);
    chk("divu_100_7_dbz", div_by_zero, 0);
    run_op("divu_big_3", TB_DIVUc, 32'h8000_0000, 32'd3, 32'h2, 32'h2AAA_AAAA);

    g = golden(TB_MULTUc, 32'd12345, 32'd6789);
    run_op("multu_gold", TB_MULTUc, 32'd12345, 32'd6789, g[2*W-1:W], g[W-1:0]);
    g = golden(TB_DIVUc, 32'hDEAD_BEEF, 32'h0000_1234);
    run_op("divu_gold", TB_DIVUc, 32'hDEAD_BEEF, 32'h0000_1234, g[2*W-1:W], g[W-1:0]);

    // Divide by zero completes immediately without busy.
    issue(TB_DIVUc, 32'h1234, 32'h0);
    chk("dz_done", done, 1);
    chk("dz_busy", busy, 0);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_flag", div_by_zero, 1);
    step();
    chk("dz_done_drop", done, 0);
    chk("dz_flag_sticky", div_by_zero, 1);
    chk("dz_state", dbg_state, IDLE);

    // A DIVU start in cycle 10 of a MULTU must be ignored.
    done_seen = 0;
    issue(TB_MULTUc, 32'd3, 32'd5);
    chk("ign_dbz_clear", div_by_zero, 0);
    for (int c = 2; c <= 10; c++) step();
    start = 1'b1; alu_ctrl = TB_DIVUc; a = 32'd9; b = 32'd2;
    step();
    start = 1'b0; alu_ctrl = ADDac;
    for (int c = 12; c <= 33; c++) step();
    chk("ign_done", done, 1);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 15);
    step(); step(); step();
    chk("ign_one_pulse", done_seen, 1);
    chk("ign_state", dbg_state, IDLE);

    // Non-muldiv control codes never start anything.
    start = 1'b1; alu_ctrl = MFHIac; a = 32'd1; b = 32'd1;
    step();
    start = 1'b0; alu_ctrl = ADDac;
    chk("mfhi_busy", busy, 0);
    chk("mfhi_state", dbg_state, IDLE);
    chk("mfhi_lo_hold", lo, 15);

    // Reset in cycle 10 aborts the operation.
    done_seen = 0;
    issue(TB_MULTUc, 32'd6, 32'd7);
    for (int c = 2; c <= 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_dbz", div_by_zero, 0);
    for (int c = 0; c < 40; c++) step();
    chk("abort_no_done", done_seen, 0);
    chk("abort_lo_stays", lo, 0);

    // Back-to-back: DIVU 50/8 then MULTU 2*3 started in the DONE cycle.
    issue(TB_DIVUc, 32'd50, 32'd8);
    for (int c = 2; c <= 33; c++) step();
    chk("b2b_done1", done, 1);
    chk("b2b_hi1", hi, 2);
    chk("b2b_lo1", lo, 6);
    start = 1'b1; alu_ctrl = TB_MULTUc; a = 32'd2; b = 32'd3;
    step();
    start = 1'b0; alu_ctrl = ADDac;
    chk("b2b_busy_rise", busy, 1);
    bad = 0;
    for (int c = 34; c <= 65; c++) begin
      if (hi !== 32'd2 || lo !== 32'd6 || busy !== 1'b1) bad++;
      step();
    end
    chk("b2b_hold", bad, 0);
    chk("b2b_done2", done, 1);
    chk("b2b_hi2", hi, 0);
    chk("b2b_lo2", lo, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit that owns the HI/LO registers of the MIPS datapath. It consumes `alu_ctrl` alongside the register-file read operands A and B. When `alu_ctrl` is MULTU or DIVU, it runs a multi-cycle shift-add or restoring-divide sequence and raises `busy` so control can stall. MFHI/MFLO are served by the result mux selecting the `hi`/`lo` outputs of this block.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request to begin the operation named by `alu_ctrl`.
- `alu_ctrl`  in  `alu_ctrl_t`: only MULTUac and DIVUac start work; all other codes are ignored.
- `a`  in  `WIDTH`: multiplicand or dividend (rs).
- `b`  in  `WIDTH`: multiplier or divisor (rt).
- `busy`  out  1: high while an operation is iterating.
- `done`  out  1: single-cycle pulse when `hi`/`lo` have just been updated.
- `hi`  out  `WIDTH`: HI register.
- `lo`  out  `WIDTH`: LO register.
- `div_by_zero`  out  1: sticky flag for the last DIVU, cleared by the next accepted start.

## Operation
States are IDLE, RUN and DONE.
- **IDLE:** on `start` with MULTUac or DIVUac (divisor ≠ 0), latch `a`/`b` and the operation into internal registers, clear the iteration counter, clear `div_by_zero`, and go to RUN.
- **IDLE, DIVU with b = 0:** go directly to DONE and set `div_by_zero`=1. On entry to DONE, `hi`=`a` and `lo`=all ones.
- **RUN:** one iteration per cycle for exactly `WIDTH` cycles, counted from 0 to `WIDTH`-1. After the last iteration, go to DONE.
  - MULTU: shift-add into a 2·`WIDTH`-bit accumulator.
  - DIVU: restoring divide; remainder is `WIDTH`+1 bits internally to capture the subtract borrow.
- **DONE:** `done`=1 for this one cycle.
  - `hi`/`lo` take their results on the DONE-entry clock edge.
  - MULTU: {hi, lo} = a·b, unsigned, exact 2·`WIDTH`-bit product.
  - DIVU: lo = quotient, hi = remainder.
  - Next state: RUN if a new valid `start` arrives this cycle (back-to-back accepted); otherwise IDLE.
- `hi`/`lo` hold their previous values throughout RUN, so MFHI/MFLO issued mid-operation read the old values.
- `start` during RUN is ignored. No queueing; control must stall on `busy`.
- `start` with any other `alu_ctrl` code has no effect in any state.

## Timing
- **Reset:** state=IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; internal accumulator and counter are zeroed.
- **Reset priority:** `rst` overrides `start` on the same edge.
- **Reset mid-RUN:** the operation is aborted, no `done` pulse is produced, and `hi`/`lo` are cleared to 0.
- **Normal latency:** `start` sampled at edge 0. `busy`=1 in cycles 1..`WIDTH`. `done`=1 and new `hi`/`lo` are visible in cycle `WIDTH`+1 (cycle 33 for `WIDTH`=32).
- **Divide-by-zero latency:** `done` and new values appear in cycle 1. `busy` never rises.
- **`busy` in DONE:** `busy`=0, so the stalled instruction can issue in that cycle.
- **Back-to-back:** a start accepted in DONE makes `busy` rise in the next cycle.
- **Counter:** `$clog2(WIDTH)` bits; terminal value `WIDTH`-1; no wrap beyond that.

## Structure
- Add to the shared `global_types` package:
  - `muldiv_state_t` enum {IDLE, RUN, DONE};
  - `muldiv_op_t` enum {MD_MULTU, MD_DIVU}.
- Reuse the existing `alu_ctrl_t`, including MULTUac, DIVUac, MFHIac and MFLOac.
- Add to the testbench package: `TB_MULTUc`/`TB_DIVUc` stimulus helpers plus a golden-model function returning {hi, lo}.
- Single module; no sub-module is natural. The multiply and divide iterations share the accumulator and counter, selected by the latched op.

## Test plan
- **MULTU, max operands:** a=0xFFFFFFFF, b=0xFFFFFFFF → in cycle 33, `hi`=0xFFFFFFFE and `lo`=0x00000001; `done` high for exactly one cycle; `busy` high in cycles 1–32.
- **DIVU, normal:** a=100, b=7 → `lo`=14, `hi`=2, `div_by_zero`=0. Also a=0x80000000, b=0x3 → `lo`=0x2AAAAAAA, `hi`=0x2.
- **DIVU by zero:** a=0x1234, b=0 → in cycle 1, `hi`=0x1234, `lo`=0xFFFFFFFF, `div_by_zero`=1; `busy` stays 0. The flag clears on the next accepted start.
- **Start ignored while busy:** start MULTU 3×5, then pulse `start` with DIVU 9/2 in cycle 10 → result is `hi`=0, `lo`=15; only one `done` pulse.
- **Reset mid-RUN:** start MULTU 6×7, assert `rst` in cycle 10 → from the next cycle all outputs are 0 and the state is IDLE; no `done` pulse follows.
- **Back-to-back, MFHI/MFLO hold:** start DIVU 50/8, then in its DONE cycle start MULTU 2×3. Required:
  - `hi`=2, `lo`=6 after the first operation;
  - those values hold through the second RUN;
  - `hi`=0, `lo`=6 after the second `done`.
